// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm UART command link.
package remote_comm_pkg;

  localparam int         BAUD_DIV_DEFAULT = 2604;
  localparam logic [7:0] RESP_ACK         = 8'hA5;
  localparam logic [3:0] STOP_BIT_IDX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_BUSY
  } rx_state_t;

endpackage

// File: rtl/remote_comm_if.sv
// Command/serial bundle between a host-side driver (master) and remote_comm (slave).
interface remote_comm_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;

  modport master (
    output cmd, send_cmd, RX,
    input  cmd_sent, TX, resp, resp_rdy
  );

  modport slave (
    input  cmd, send_cmd, RX,
    output cmd_sent, TX, resp, resp_rdy
  );
endinterface

// File: rtl/remote_comm_uart_tx.sv
// 8N1 UART transmitter; a trmt strobe on the tx_done cycle chains frames with no idle gap.
module uart_tx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_trmt,
  output logic       o_tx,
  output logic       o_tx_done
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic [15:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_shift;
  logic        r_busy;
  logic        r_tx;
  logic        w_bit_end;

  assign w_bit_end = r_busy && (r_baud_cnt == BAUD_LAST);
  // Combinational so the caller can issue the next trmt in the same cycle.
  assign o_tx_done = w_bit_end && (r_bit_cnt == STOP_BIT_IDX);
  assign o_tx      = r_tx;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '1;
    end else if (i_trmt) begin
      r_busy     <= 1'b1;
      r_tx       <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= {1'b1, i_tx_data};
    end else if (w_bit_end) begin
      r_baud_cnt <= '0;
      if (r_bit_cnt == STOP_BIT_IDX) begin
        r_busy <= 1'b0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_tx      <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
      end
    end else if (r_busy) begin
      r_baud_cnt <= r_baud_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side UART command link: 16-bit command out as two frames, response bytes in.
// The receive path is built only when REMOTE_COMM_RX_EN is defined.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  remote_comm_if.slave bus
);

  tx_state_t  r_tx_state;
  logic [7:0] r_cmd_lo;
  logic       r_cmd_sent;
  logic       w_accept;
  logic       w_trmt;
  logic       w_tx_done;
  logic       w_tx;
  logic [7:0] w_tx_byte;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_accept  = bus.send_cmd && ((r_tx_state == IDLE) || (r_tx_state == DONE));
    w_trmt    = w_accept || ((r_tx_state == HIGH) && w_tx_done);
    w_tx_byte = w_accept ? bus.cmd[15:8] : r_cmd_lo;
  end

  // The high byte goes straight to the transmitter, so only the low byte is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_cmd_lo   <= '0;
      r_cmd_sent <= 1'b0;
    end else begin
      case (r_tx_state)
        IDLE, DONE: if (bus.send_cmd) begin
          r_cmd_lo   <= bus.cmd[7:0];
          r_cmd_sent <= 1'b0;
          r_tx_state <= HIGH;
        end
        HIGH: if (w_tx_done) r_tx_state <= LOW;
        LOW: if (w_tx_done) begin
          r_cmd_sent <= 1'b1;
          r_tx_state <= DONE;
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .i_tx_data (w_tx_byte),
    .i_trmt    (w_trmt),
    .o_tx      (w_tx),
    .o_tx_done (w_tx_done)
  );

  assign bus.TX       = w_tx;
  assign bus.cmd_sent = r_cmd_sent;

`ifdef REMOTE_COMM_RX_EN
  localparam logic [15:0] RX_HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] RX_FULL_LAST = 16'(BAUD_DIV - 1);

  logic        r_rx_sync1;
  logic        r_rx_sync2;
  logic        r_rx_prev;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_baud;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_resp;
  logic        r_resp_rdy;
  logic        w_rx_sample;

  always_comb begin
    w_rx_sample = (r_rx_state == RX_BUSY) &&
                  (r_rx_baud == ((r_rx_bit == 4'd0) ? RX_HALF_LAST : RX_FULL_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= bus.RX;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  // Framing errors are deliberately ignored: the stop-bit sample always completes the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_resp     <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_sync2) begin
          r_rx_state <= RX_BUSY;
          r_rx_baud  <= '0;
          r_rx_bit   <= '0;
          r_resp_rdy <= 1'b0;
        end
        RX_BUSY: begin
          if (!w_rx_sample) begin
            r_rx_baud <= r_rx_baud + 16'd1;
          end else begin
            r_rx_baud <= '0;
            if ((r_rx_bit == 4'd0) && r_rx_sync2) begin
              r_rx_state <= RX_IDLE;
            end else if (r_rx_bit == STOP_BIT_IDX) begin
              r_resp     <= r_rx_shift;
              r_resp_rdy <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              if (r_rx_bit != 4'd0) r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
              r_rx_bit <= r_rx_bit + 4'd1;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.resp     = r_resp;
  assign bus.resp_rdy = r_resp_rdy;
`else
  logic w_unused_rx;
  assign w_unused_rx  = bus.RX;
  assign bus.resp     = 8'h00;
  assign bus.resp_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_remote_comm.sv
// Directed + randomized bench for remote_comm: TX waveform checked cycle-by-cycle
// against an arithmetic frame model, RX bytes driven as 8N1 frames.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int BD     = 8;
  localparam int BD_BIG = BAUD_DIV_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  remote_comm_if bus0 ();
  remote_comm_if bus1 ();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  remote_comm #(.BAUD_DIV(BD_BIG)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected c clocks after the command is accepted: two 10-bit frames, high byte first.
  function automatic logic exp_tx(input logic [15:0] v, input int bd, input int c);
    int         f;
    int         b;
    logic [7:0] byte_v;
    f      = c / (10 * bd);
    b      = (c % (10 * bd)) / bd;
    byte_v = (f == 0) ? v[15:8] : v[7:0];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return byte_v[b - 1];
  endfunction

  task automatic drive_cmd(input bit sel, input logic [15:0] v, input logic go);
    if (sel) begin
      bus1.cmd = v; bus1.send_cmd = go;
    end else begin
      bus0.cmd = v; bus0.send_cmd = go;
    end
  endtask

  // Send v, watch 20*bd+1 cycles; optionally inject a second request at cycle ign_at.
  task automatic run_tx(input bit sel, input int bd, input logic [15:0] v,
                        input int ign_at, input logic [15:0] ign_v, input string tag);
    int   bad[20];
    int   early;
    logic tx;
    logic cs;
    foreach (bad[i]) bad[i] = 0;
    early = 0;
    @(posedge clk); #1;
    drive_cmd(sel, v, 1'b1);
    @(posedge clk); #1;
    drive_cmd(sel, v, 1'b0);
    for (int c = 0; c <= 20 * bd; c++) begin
      @(negedge clk);
      tx = sel ? bus1.TX : bus0.TX;
      cs = sel ? bus1.cmd_sent : bus0.cmd_sent;
      if (c < 20 * bd) begin
        if (tx !== exp_tx(v, bd, c)) bad[c / bd]++;
        if (cs !== 1'b0) early++;
      end else begin
        check({tag, " cmd_sent_rise"}, {31'd0, cs}, 32'd1);
        check({tag, " tx_idle_after"}, {31'd0, tx}, 32'd1);
      end
      if (c == ign_at) drive_cmd(sel, ign_v, 1'b1);
      if (c == ign_at + 1) drive_cmd(sel, ign_v, 1'b0);
    end
    for (int b = 0; b < 20; b++) check($sformatf("%s bit%0d bad_cycles", tag, b), bad[b], 0);
    check({tag, " cmd_sent_low_while_busy"}, early, 0);
  endtask

  // Drive one 8N1 frame on RX of the small DUT; report the first resp_rdy rise and the level early in the frame.
  task automatic drive_rx(input logic [7:0] b, output int rise, output logic rdy5);
    logic val;
    rise = -1;
    rdy5 = 1'bx;
    for (int cyc = 1; cyc <= 10 * BD; cyc++) begin
      case ((cyc - 1) / BD)
        0:       val = 1'b0;
        9:       val = 1'b1;
        default: val = b[(cyc - 1) / BD - 1];
      endcase
      bus0.RX = val;
      @(posedge clk);
      @(negedge clk);
      if (cyc == 5) rdy5 = bus0.resp_rdy;
      if (rise < 0 && cyc >= 10 && bus0.resp_rdy === 1'b1) rise = cyc - 1;
    end
    bus0.RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic run_rx(input logic [7:0] b, input string tag);
    int   rise;
    logic rdy5;
    drive_rx(b, rise, rdy5);
`ifdef REMOTE_COMM_RX_EN
    check({tag, " rdy_low_at_start"}, {31'd0, rdy5}, 32'd0);
    check({tag, " rdy_latency_in_window"}, {31'd0, (rise >= 77 && rise <= 79)}, 32'd1);
    check({tag, " resp"}, {24'd0, bus0.resp}, {24'd0, b});
`else
    check({tag, " rdy_never"}, rise, -1);
    check({tag, " resp_tied"}, {24'd0, bus0.resp}, 32'd0);
`endif
  endtask

  initial begin
    int          hi;
    logic [15:0] rv;
    logic [7:0]  rb;
    bus0.cmd = '0; bus0.send_cmd = 1'b0; bus0.RX = 1'b1;
    bus1.cmd = '0; bus1.send_cmd = 1'b0; bus1.RX = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset TX", {31'd0, bus0.TX}, 32'd1);
    check("reset cmd_sent", {31'd0, bus0.cmd_sent}, 32'd0);
    check("reset resp_rdy", {31'd0, bus0.resp_rdy}, 32'd0);
    check("reset resp", {24'd0, bus0.resp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_tx(1'b0, BD, 16'h43F1, -10, 16'h0, "t1_43F1");
    // Re-arm straight out of DONE, with a competing request in the middle of the high byte.
    run_tx(1'b0, BD, 16'h43F1, 5 * BD, 16'h1234, "t3_ignore");

    // Reset in the middle of bit 3 of the high-byte frame (data[2] of 0x43 is 0).
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h43F1, 1'b1);
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h43F1, 1'b0);
    repeat (3 * BD + BD / 2) @(posedge clk);
    @(negedge clk);
    check("t4 tx_before_rst", {31'd0, bus0.TX}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4 tx_after_rst", {31'd0, bus0.TX}, 32'd1);
    check("t4 cmd_sent_after_rst", {31'd0, bus0.cmd_sent}, 32'd0);
    run_tx(1'b0, BD, 16'h43F1, -10, 16'h0, "t4_fresh");

    // Short low glitch on RX must not produce a byte.
    @(posedge clk); #1;
    bus0.RX = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus0.RX = 1'b1;
    hi = 0;
    repeat (12 * BD) begin
      @(negedge clk);
      if (bus0.resp_rdy !== 1'b0) hi++;
    end
    check("t5 glitch_no_rdy", hi, 0);

    run_rx(RESP_ACK, "t2_A5");
    check("t2 rdy_held_before_5A", {31'd0, bus0.resp_rdy}, {31'd0, bus0.resp === RESP_ACK});
    run_rx(8'h5A, "t2_5A");

    for (int n = 0; n < 3; n++) begin
      rv = 16'($urandom);
      run_tx(1'b0, BD, rv, -10, 16'h0, $sformatf("rand_tx%0d_%04h", n, rv));
      rb = 8'($urandom);
      run_rx(rb, $sformatf("rand_rx%0d_%02h", n, rb));
    end

    run_tx(1'b1, BD_BIG, 16'h2A20, -10, 16'h0, "t6_2A20_big");
    check("t6 big_resp_rdy", {31'd0, bus1.resp_rdy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
